// File: rtl/uop_queue.sv
// Circular microop FIFO between the microcode expander and decode_rename.
// Holds {uop, macro PC} entries and pops the head only on rename success.
module uop_queue #(
    parameter int DEPTH = 8,
    parameter int UOP_W = 24,
    parameter int PC_W  = 16,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [UOP_W-1:0] in_uop,
    input  logic [PC_W-1:0]  in_pc,
    output logic             in_ready,
    output logic             out_valid,
    output logic [UOP_W-1:0] out_uop,
    output logic [PC_W-1:0]  out_pc,
    input  logic             out_accept,
    output logic [CNT_W-1:0] count
);

    logic [UOP_W-1:0] uop_mem [DEPTH];
    logic [PC_W-1:0]  pc_mem  [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic             push;
    logic             pop;

    // Readiness looks only at the registered count, never at a same-cycle pop.
    assign in_ready  = (count != CNT_W'(DEPTH));
    assign out_valid = (count != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_accept & out_valid;

    assign out_uop = out_valid ? uop_mem[head] : '0;
    assign out_pc  = out_valid ? pc_mem[head]  : '0;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) tail <= tail + PTR_W'(1);
            if (pop)  head <= head + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage is data only: never cleared, written just on an accepted push.
    always_ff @(posedge clk) begin
        if (push && !rst && !flush) begin
            uop_mem[tail] <= in_uop;
            pc_mem[tail]  <= in_pc;
        end
    end

`ifndef SYNTHESIS
    a_in_stable : assert property (@(posedge clk) disable iff (rst)
        (in_valid && !in_ready) |=> (!in_valid || ($stable(in_uop) && $stable(in_pc))));
    a_count_max : assert property (@(posedge clk) disable iff (rst)
        count <= CNT_W'(DEPTH));
`endif

endmodule

// File: doc/uop_queue.md
Name: uop_queue

Overview:
- Circular FIFO between the microcode expander and decode_rename.
- Buffers 24-bit microops, each tagged with its 16-bit macro PC.
- Presents the head entry to rename and pops it only when rename reports success.
- Absorbs rename stalls caused by physical-register exhaustion; supports a single-cycle flush for redirects.

Parameters:
DEPTH, 8, number of entries; power of two, >= 2
UOP_W, 24, microop width
PC_W, 16, macro PC width

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
flush  input  1  discard all entries
in_valid  input  1  expander offers a microop
in_uop  input  UOP_W  offered microop
in_pc  input  PC_W  macro PC of offered microop
in_ready  output  1  queue can accept this cycle
out_valid  output  1  head entry present
out_uop  output  UOP_W  head microop, to decode_rename instr
out_pc  output  PC_W  head macro PC, to decode_rename macro_pc
out_accept  input  1  rename_success from decode_rename; pops head
count  output  clog2(DEPTH+1)  current occupancy

Behaviour:
- State:
  - head and tail pointers, each clog2(DEPTH) bits, wrapping modulo DEPTH.
  - count register.
  - Storage array of {uop, pc} entries.
- Reset (rst high at a clk edge):
  - Pointers and count go to 0.
  - out_valid=0, in_ready=1, count=0, out_uop=0, out_pc=0.
  - Storage contents are not cleared.
- push = in_valid & in_ready. On push, write {in_uop, in_pc} at tail, then tail+1.
- pop = out_accept & out_valid. On pop, head+1.
- out_accept while out_valid=0 is ignored (no pointer movement, no underflow).
- count update: +1 if push only, -1 if pop only, unchanged if both or neither.
- in_ready = (count != DEPTH). It is purely a function of registered count and does not look ahead to a same-cycle pop. A full queue refuses input even while popping.
- out_valid = (count != 0).
- out_uop/out_pc:
  - Driven combinationally from storage[head] when out_valid=1.
  - Forced to 0 when out_valid=0.
- Latency and ordering:
  - Write-to-read latency is 1 cycle: a microop pushed at edge N is visible at the head after edge N if the queue was empty. There is no same-cycle bypass.
  - Strict FIFO order.
  - Head outputs stay stable while out_valid=1 and out_accept=0, so rename may retry across stall cycles.
- Simultaneous push and pop:
  - Allowed at any non-full, non-empty occupancy; count is unchanged and both pointers advance.
  - When empty: only the push occurs, because out_valid=0.
  - When full: only the pop occurs, because in_ready=0.
- Pointer wrap: tail and head roll from DEPTH-1 to 0 silently; fullness comes from count, not pointer comparison.
- flush:
  - At the edge, head=tail=0 and count=0.
  - Any same-cycle push or pop is discarded.
  - The next cycle shows out_valid=0, in_ready=1.
- rst has priority over flush. flush has priority over push and pop.
- Reset mid-operation: all in-flight entries are lost. No partial state survives.
- Assertion-only checks (synthesis-ignored):
  - in_uop and in_pc stay stable while in_valid=1 and in_ready=0.
  - count never exceeds DEPTH.

Test Plan:
- Reset then idle:
  - Stimulus: after rst, hold in_valid=0.
  - Required: out_valid=0, in_ready=1, count=0, out_uop=0, out_pc=0.
- Fill and drain:
  - Stimulus: push uops 0x100001..0x100008 with pc 0x8000..0x8007, holding out_accept=0.
  - Required: count reaches 8, then in_ready=0.
  - Stimulus: a ninth push of 0x1FFFFF.
  - Required: it is rejected.
  - Stimulus: assert out_accept continuously.
  - Required: head values appear in order 0x100001..0x100008, count falls to 0.
- Stall hold:
  - Stimulus: push 0xABCDEF with pc 0x1234, then hold out_accept=0 for 5 cycles.
  - Required: out_uop=0xABCDEF and out_pc=0x1234 held steady for all 5 cycles.
  - Stimulus: out_accept=1 for 1 cycle.
  - Required: out_valid=0 on the next cycle.
- Wrap with concurrency:
  - Stimulus: preload 3 entries, then push and pop every cycle for 20 cycles.
  - Required: count stays 3, outputs follow FIFO order across pointer wrap, no loss or duplication.
- Flush mid-stream:
  - Stimulus: with 5 entries queued, assert flush together with in_valid=1 and out_accept=1.
  - Required: next cycle count=0, out_valid=0; the offered uop is absent from later output.
  - Stimulus: a subsequent push of 0x000042.
  - Required: 0x000042 appears at the head.
- Full-queue edge cases:
  - Stimulus: when full, assert in_valid=1 and out_accept=1 in the same cycle.
  - Required: only the pop occurs, count=7.
  - Stimulus: assert rst and flush together.
  - Required: reset values appear.
